// File: rtl/sequential_divider_module.sv
// Multi-cycle unsigned restoring divider with a start/busy/done handshake.
// One quotient bit is resolved per clock using a ripple trial subtractor;
// the dividend register shifts left and collects the quotient bits.
// Handshake: start is sampled on any rising edge while idle or done. An
// accepted start with a nonzero divisor runs bit_width steps (busy high).
// A zero divisor completes on the same edge. done is a one-cycle pulse
// marking that quotient/remainder/divide_by_zero were just loaded.
module sequential_divider_module #(
    parameter int bit_width = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [bit_width-1:0] dividend,
    input  logic [bit_width-1:0] divisor,
    output logic                 busy,
    output logic                 done,
    output logic [bit_width-1:0] quotient,
    output logic [bit_width-1:0] remainder,
    output logic                 divide_by_zero
);

    localparam int cnt_w = $clog2(bit_width + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [bit_width-1:0] a_q, a_d;        // shifting dividend / quotient
    logic [bit_width-1:0] d_q, d_d;        // captured divisor
    logic [bit_width:0]   r_q, r_d;        // partial remainder
    logic [cnt_w-1:0]     cnt_q, cnt_d;    // steps left
    logic [bit_width-1:0] quot_q, quot_d;
    logic [bit_width-1:0] rem_q, rem_d;
    logic                 dbz_q, dbz_d;

    logic [bit_width:0]   s_val;
    logic [bit_width:0]   d_ext;
    logic [bit_width:0]   t_val;
    logic [bit_width+1:0] borrow;
    logic                 q_bit;
    logic [bit_width-1:0] a_next;

    // Trial subtract S - D through a ripple-borrow chain; borrow-out picks the quotient bit.
    always_comb begin
        s_val  = {r_q[bit_width-1:0], a_q[bit_width-1]};
        d_ext  = {1'b0, d_q};
        borrow = '0;
        t_val  = '0;
        for (int i = 0; i <= bit_width; i++) begin
            t_val[i]    = s_val[i] ^ d_ext[i] ^ borrow[i];
            borrow[i+1] = (~s_val[i] & d_ext[i]) | (~(s_val[i] ^ d_ext[i]) & borrow[i]);
        end
        q_bit  = ~borrow[bit_width+1];
        a_next = {a_q[bit_width-2:0], q_bit};
    end

    // Next-state and datapath updates; IDLE and DONE accept start identically.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    if (divisor == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                        a_d     = dividend;
                        d_d     = divisor;
                        r_d     = '0;
                        cnt_d   = cnt_w'(bit_width);
                    end
                end
            end
            RUN: begin
                r_d   = q_bit ? t_val : s_val;
                a_d   = a_next;
                cnt_d = cnt_q - cnt_w'(1);
                if (cnt_q == cnt_w'(1)) begin
                    state_d = DONE;
                    quot_d  = a_next;
                    rem_d   = q_bit ? t_val[bit_width-1:0] : s_val[bit_width-1:0];
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any division in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy           = (state_q == RUN);
    assign done           = (state_q == DONE);
    assign quotient       = quot_q;
    assign remainder      = rem_q;
    assign divide_by_zero = dbz_q;

endmodule

// File: tb/tb_sequential_divider_module.sv
// Testbench for sequential_divider_module (bit_width = 8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sequential_divider_module;
  localparam int W = 8;

  logic         clock;
  logic         reset_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         divide_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2*W:0] exp_q[$];

  sequential_divider_module #(.bit_width(W)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .dividend       (dividend),
    .divisor        (divisor),
    .busy           (busy),
    .done           (done),
    .quotient       (quotient),
    .remainder      (remainder),
    .divide_by_zero (divide_by_zero)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model: {divide_by_zero, quotient, remainder}
  function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    int ai, bi;
    ai = int'(a);
    bi = int'(b);
    if (bi == 0) return {1'b1, {W{1'b1}}, a};
    return {1'b0, W'(ai / bi), W'(ai % bi)};
  endfunction

  // driver: issue one division, wait for done; cyc = falling edges from start to done
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z, output int cyc, output int bcnt);
    @(negedge clock);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clock);
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    cyc  = 1;
    bcnt = 0;
    while (!done && cyc < 40) begin
      if (busy) bcnt++;
      @(negedge clock);
      cyc++;
    end
    q = quotient;
    r = remainder;
    z = divide_by_zero;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clock);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (quotient !== '0) begin n_fail++; $display("FAIL reset_quotient got=%0d exp=0", quotient); end
    n_checks++; if (remainder !== '0) begin n_fail++; $display("FAIL reset_remainder got=%0d exp=0", remainder); end
    n_checks++; if (divide_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got=%b exp=0", divide_by_zero); end
    reset_n = 1'b1;
    @(negedge clock);
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle busy=%b done=%b exp 0 0", busy, done); end
  endtask

  task automatic test_normal();
    logic [W-1:0] q, r;
    logic z;
    int cyc, bcnt;
    run_div(8'd200, 8'd7, q, r, z, cyc, bcnt);
    n_checks++; if (cyc !== W + 1) begin n_fail++; $display("FAIL normal_latency got=%0d exp=%0d", cyc, W + 1); end
    n_checks++; if (bcnt !== W) begin n_fail++; $display("FAIL normal_busy_cycles got=%0d exp=%0d", bcnt, W); end
    n_checks++; if (q !== 8'd28) begin n_fail++; $display("FAIL normal_quotient got=%0d exp=28", q); end
    n_checks++; if (r !== 8'd4) begin n_fail++; $display("FAIL normal_remainder got=%0d exp=4", r); end
    n_checks++; if (z !== 1'b0) begin n_fail++; $display("FAIL normal_dbz got=%b exp=0", z); end
    @(negedge clock);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL normal_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_edges();
    logic [W-1:0] ta[4];
    logic [W-1:0] tb[4];
    logic [W-1:0] tq[4];
    logic [W-1:0] tr[4];
    logic [W-1:0] q, r;
    logic z;
    int cyc, bcnt;
    ta = '{8'd255, 8'd5, 8'd0, 8'd255};
    tb = '{8'd1,   8'd9, 8'd3, 8'd255};
    tq = '{8'd255, 8'd0, 8'd0, 8'd1};
    tr = '{8'd0,   8'd5, 8'd0, 8'd0};
    for (int i = 0; i < 4; i++) begin
      run_div(ta[i], tb[i], q, r, z, cyc, bcnt);
      n_checks++;
      if (q !== tq[i] || r !== tr[i] || z !== 1'b0 || cyc !== W + 1) begin
        n_fail++;
        $display("FAIL edge_%0d_%0d got q=%0d r=%0d z=%b lat=%0d exp q=%0d r=%0d z=0 lat=%0d",
                 ta[i], tb[i], q, r, z, cyc, tq[i], tr[i], W + 1);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] q, r;
    logic z;
    int cyc, bcnt;
    run_div(8'd77, 8'd0, q, r, z, cyc, bcnt);
    n_checks++; if (cyc !== 1) begin n_fail++; $display("FAIL dbz_latency got=%0d exp=1", cyc); end
    n_checks++; if (bcnt !== 0) begin n_fail++; $display("FAIL dbz_busy_cycles got=%0d exp=0", bcnt); end
    n_checks++; if (q !== 8'd255 || r !== 8'd77 || z !== 1'b1) begin
      n_fail++; $display("FAIL dbz_result got q=%0d r=%0d z=%b exp q=255 r=77 z=1", q, r, z);
    end
    run_div(8'd10, 8'd3, q, r, z, cyc, bcnt);
    n_checks++; if (q !== 8'd3 || r !== 8'd1 || z !== 1'b0) begin
      n_fail++; $display("FAIL after_dbz got q=%0d r=%0d z=%b exp q=3 r=1 z=0", q, r, z);
    end
  endtask

  task automatic test_back_to_back();
    int c, c2;
    @(negedge clock);
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 8'd10;
    @(negedge clock);
    dividend = 8'd99;
    divisor  = 8'd4;
    c = 1;
    while (!done && c < 40) begin
      @(negedge clock);
      c++;
    end
    n_checks++; if (c !== W + 1) begin n_fail++; $display("FAIL b2b_first_latency got=%0d exp=%0d", c, W + 1); end
    n_checks++; if (quotient !== 8'd10 || remainder !== 8'd0) begin
      n_fail++; $display("FAIL b2b_first got q=%0d r=%0d exp q=10 r=0", quotient, remainder);
    end
    c2 = 0;
    do begin
      @(negedge clock);
      c2++;
    end while (!done && c2 < 40);
    n_checks++; if (c2 !== W + 1) begin n_fail++; $display("FAIL b2b_gap got=%0d exp=%0d", c2, W + 1); end
    n_checks++; if (quotient !== 8'd24 || remainder !== 8'd3 || divide_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second got q=%0d r=%0d z=%b exp q=24 r=3 z=0", quotient, remainder, divide_by_zero);
    end
    start = 1'b0;
    @(negedge clock);
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_return_idle done=%b busy=%b exp 0 0", done, busy);
    end
  endtask

  task automatic test_toggle_mid_run();
    int c;
    logic held;
    @(negedge clock);
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd7;
    @(negedge clock);
    c    = 1;
    held = 1'b1;
    while (!done && c < 40) begin
      if (quotient !== 8'd24 || remainder !== 8'd3) held = 1'b0;
      start    = 1'($urandom);
      dividend = W'($urandom);
      divisor  = W'($urandom);
      @(negedge clock);
      c++;
    end
    start = 1'b0;
    n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL results_held_during_run got=%b exp=1", held); end
    n_checks++; if (c !== W + 1) begin n_fail++; $display("FAIL toggle_latency got=%0d exp=%0d", c, W + 1); end
    n_checks++; if (quotient !== 8'd28 || remainder !== 8'd4) begin
      n_fail++; $display("FAIL toggle_result got q=%0d r=%0d exp q=28 r=4", quotient, remainder);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] q, r;
    logic z;
    int cyc, bcnt;
    logic saw_done;
    @(negedge clock);
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd7;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL midreset_ctrl busy=%b done=%b exp 0 0", busy, done);
    end
    n_checks++; if (quotient !== '0 || remainder !== '0 || divide_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL midreset_results q=%0d r=%0d z=%b exp 0 0 0", quotient, remainder, divide_by_zero);
    end
    saw_done = 1'b0;
    repeat (2) begin
      @(negedge clock);
      if (done) saw_done = 1'b1;
    end
    reset_n = 1'b1;
    repeat (W + 2) begin
      @(negedge clock);
      if (done) saw_done = 1'b1;
    end
    n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL midreset_no_done got=%b exp=0", saw_done); end
    run_div(8'd50, 8'd6, q, r, z, cyc, bcnt);
    n_checks++; if (q !== 8'd8 || r !== 8'd2 || z !== 1'b0) begin
      n_fail++; $display("FAIL after_midreset got q=%0d r=%0d z=%b exp q=8 r=2 z=0", q, r, z);
    end
  endtask

  task automatic test_divisor_sweep();
    logic [W-1:0] q, r;
    logic z;
    logic [2*W:0] e;
    int cyc, bcnt;
    for (int b = 0; b < 256; b++) begin
      e = ref_div(8'd255, W'(b));
      run_div(8'd255, W'(b), q, r, z, cyc, bcnt);
      n_checks++;
      if ({z, q, r} !== e) begin
        n_fail++;
        $display("FAIL sweep_255_%0d got z=%b q=%0d r=%0d exp z=%b q=%0d r=%0d",
                 b, z, q, r, e[2*W], e[2*W-1:W], e[W-1:0]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, q, r;
    logic z;
    logic [2*W:0] e;
    int cyc, bcnt;
    for (int n = 0; n < 2000; n++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      exp_q.push_back(ref_div(a, b));
      run_div(a, b, q, r, z, cyc, bcnt);
      e = exp_q.pop_front();
      n_checks++;
      if ({z, q, r} !== e) begin
        n_fail++;
        $display("FAIL random_%0d_%0d got z=%b q=%0d r=%0d exp z=%b q=%0d r=%0d",
                 a, b, z, q, r, e[2*W], e[2*W-1:W], e[W-1:0]);
      end
      n_checks++;
      if (cyc !== ((b == '0) ? 1 : W + 1) || bcnt !== ((b == '0) ? 0 : W)) begin
        n_fail++;
        $display("FAIL random_timing_%0d_%0d got lat=%0d busy=%0d", a, b, cyc, bcnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_edges();
    test_div_zero();
    test_back_to_back();
    test_toggle_mid_run();
    test_reset_mid();
    test_divisor_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
